// File: rtl/mux_2_1_rr.sv
// mux_2_1_rr: 2-to-1 stream merger with valid/ready handshakes and
// round-robin arbitration, feeding a single registered output slot.
// Each output beat is tagged with its source lane (0 = lane 0, 1 = lane 1).
//
// Optional feature macro: MUX_2_1_RR_FIXED_PRIO_EN
//   defined   -> fixed priority, lane 0 wins every contention
//   undefined -> round-robin, alternating under continuous contention
//
// Parameters:
//   DATA_WIDTH  width of each data lane
//   CNT_WIDTH   width of the accepted-beat counter
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in0_valid  lane 0 beat valid
//   in0_data   lane 0 data
//   in0_ready  lane 0 beat accepted this cycle (with in0_valid)
//   in1_valid  lane 1 beat valid
//   in1_data   lane 1 data
//   in1_ready  lane 1 beat accepted this cycle (with in1_valid)
//   o_valid    registered output beat valid
//   o_data     registered output data
//   o_sel      registered source lane of the output beat
//   o_ready    downstream accept
//   beat_cnt   beats accepted from the inputs, modulo 2^CNT_WIDTH
module mux_2_1_rr #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in0_valid,
  input  logic [DATA_WIDTH-1:0] in0_data,
  output logic                  in0_ready,
  input  logic                  in1_valid,
  input  logic [DATA_WIDTH-1:0] in1_data,
  output logic                  in1_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_sel,
  input  logic                  o_ready,
  output logic [CNT_WIDTH-1:0]  beat_cnt
);

  logic vld0_p0;
  logic vld1_p0;
  logic slot_free_p0;
  logic grant_vld_p0;
  logic grant_p0;
  logic accept_p0;

  // Valids are masked while reset is held so neither ready can rise even
  // though the empty output slot would otherwise look free.
  assign vld0_p0      = in0_valid & rst_n;
  assign vld1_p0      = in1_valid & rst_n;
  assign slot_free_p0 = ~o_valid | o_ready;

`ifdef MUX_2_1_RR_FIXED_PRIO_EN
  always_comb begin
    grant_vld_p0 = vld0_p0 | vld1_p0;
    grant_p0     = ~vld0_p0;
  end
`else
  logic last_grant;

  always_comb begin
    grant_vld_p0 = vld0_p0 | vld1_p0;
    grant_p0     = 1'b0;
    if (vld0_p0 && vld1_p0) begin
      grant_p0 = ~last_grant;
    end else if (vld1_p0) begin
      grant_p0 = 1'b1;
    end
  end

  // Reset to lane 1 so lane 0 takes the first contention. Only updated on
  // an accept, so a stall or an idle cycle never moves the turn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (accept_p0) begin
      last_grant <= grant_p0;
    end
  end
`endif

  assign accept_p0 = slot_free_p0 & grant_vld_p0;
  // A granted lane is always a valid lane, so accept plus grant is enough.
  assign in0_ready = accept_p0 & ~grant_p0;
  assign in1_ready = accept_p0 &  grant_p0;

  // ---- output slot register (p0 -> output) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_sel    <= 1'b0;
      beat_cnt <= '0;
    end else if (accept_p0) begin
      o_valid  <= 1'b1;
      o_data   <= grant_p0 ? in1_data : in0_data;
      o_sel    <= grant_p0;
      beat_cnt <= beat_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else if (o_ready) begin
      // Beat drained with nothing to replace it; data and tag keep their
      // last values.
      o_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_2_1_rr.sv
module tb_mux_2_1_rr;

`ifdef MUX_2_1_RR_FIXED_PRIO_EN
  localparam bit RR = 1'b0;
`else
  localparam bit RR = 1'b1;
`endif

  logic        clk;
  logic        rst_n;
  logic        in0_valid;
  logic [15:0] in0_data;
  logic        in0_ready;
  logic        in1_valid;
  logic [15:0] in1_data;
  logic        in1_ready;
  logic        o_valid;
  logic [15:0] o_data;
  logic        o_sel;
  logic        o_ready;
  logic [7:0]  beat_cnt;

  // narrow-counter instance shares all inputs with the main one
  logic        n_in0_ready;
  logic        n_in1_ready;
  logic        n_o_valid;
  logic [15:0] n_o_data;
  logic        n_o_sel;
  logic [3:0]  n_beat_cnt;

  int passed = 0;
  int total  = 0;
  logic [16:0] exp_q[$];

  mux_2_1_rr #(.DATA_WIDTH(16), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
    .o_valid(o_valid), .o_data(o_data), .o_sel(o_sel), .o_ready(o_ready),
    .beat_cnt(beat_cnt)
  );

  mux_2_1_rr #(.DATA_WIDTH(16), .CNT_WIDTH(4)) dut_n (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(n_in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(n_in1_ready),
    .o_valid(n_o_valid), .o_data(n_o_data), .o_sel(n_o_sel), .o_ready(o_ready),
    .beat_cnt(n_beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Upstream rule: a pending beat stays valid with stable data.
  a_hold0: assert property (@(posedge clk) disable iff (!rst_n)
    (in0_valid && !in0_ready) |=> (in0_valid && $stable(in0_data)));
  a_hold1: assert property (@(posedge clk) disable iff (!rst_n)
    (in1_valid && !in1_ready) |=> (in1_valid && $stable(in1_data)));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      passed++;
  endtask

  // Monitor: every beat the downstream takes is popped and compared.
  always @(negedge clk) begin
    if (rst_n && o_valid && o_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL out_beat: got sel=%0d data=%0h expected no beat", o_sel, o_data);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        if ({o_sel, o_data} !== e)
          $display("FAIL out_beat: got sel=%0d data=%0h expected sel=%0d data=%0h",
                   o_sel, o_data, e[16], e[15:0]);
        else
          passed++;
      end
    end
  end

  // One cycle of stimulus: drive, check readys against the hand-computed
  // grant, and queue the beat expected to emerge.
  task automatic step(input logic v0, input logic [15:0] d0,
                      input logic v1, input logic [15:0] d1,
                      input logic ordy, input logic er0, input logic er1);
    @(posedge clk);
    #1;
    in0_valid = v0; in0_data = d0;
    in1_valid = v1; in1_data = d1;
    o_ready   = ordy;
    #1;
    chk("in0_ready", {31'd0, in0_ready}, {31'd0, er0});
    chk("in1_ready", {31'd0, in1_ready}, {31'd0, er1});
    if (er0) exp_q.push_back({1'b0, d0});
    if (er1) exp_q.push_back({1'b1, d1});
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    in0_valid = 1'b1; in1_valid = 1'b1;
    #1;
    chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_o_data", {16'd0, o_data}, 32'd0);
    chk("rst_o_sel", {31'd0, o_sel}, 32'd0);
    chk("rst_beat_cnt", {24'd0, beat_cnt}, 32'd0);
    chk("rst_narrow_cnt", {28'd0, n_beat_cnt}, 32'd0);
    chk("rst_in0_ready", {31'd0, in0_ready}, 32'd0);
    chk("rst_in1_ready", {31'd0, in1_ready}, 32'd0);
    in0_valid = 1'b0; in1_valid = 1'b0;
    exp_q.delete();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    in0_valid = 1'b0; in0_data = '0;
    in1_valid = 1'b0; in1_data = '0;
    o_ready = 1'b0;

    // single lane-0 beat after reset
    do_reset();
    step(1'b1, 16'h00A5, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    chk("t1_o_valid", {31'd0, o_valid}, 32'd1);
    chk("t1_o_data", {16'd0, o_data}, 32'h00A5);
    chk("t1_o_sel", {31'd0, o_sel}, 32'd0);
    chk("t1_beat_cnt", {24'd0, beat_cnt}, 32'd1);

    // continuous contention
    do_reset();
    for (int i = 0; i < 6; i++) begin
      logic e0;
      e0 = RR ? (i % 2 == 0) : 1'b1;
      step(1'b1, 16'h1111, 1'b1, 16'h2222, 1'b1, e0, ~e0);
    end
    // drain the lane left pending so its valid can drop legally
    if (RR) step(1'b1, 16'h1111, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    else    step(1'b0, 16'h0, 1'b1, 16'h2222, 1'b1, 1'b0, 1'b1);
    chk("t2_beat_cnt", {24'd0, beat_cnt}, 32'd6);

    // stall holding 0x3333 while both lanes wait
    step(1'b1, 16'h3333, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 16'h5555, 1'b1, 16'h6666, 1'b0, 1'b0, 1'b0);
      chk("stall_o_valid", {31'd0, o_valid}, 32'd1);
      chk("stall_o_data", {16'd0, o_data}, 32'h3333);
      chk("stall_o_sel", {31'd0, o_sel}, 32'd0);
    end
    // last accepted beat came from lane 0, so round-robin hands lane 1 the turn
    step(1'b1, 16'h5555, 1'b1, 16'h6666, 1'b1, ~RR, RR);
    if (RR) step(1'b1, 16'h5555, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    else    step(1'b0, 16'h0, 1'b1, 16'h6666, 1'b1, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    chk("t3_o_valid_drop", {31'd0, o_valid}, 32'd0);
    chk("t3_beat_cnt", {24'd0, beat_cnt}, 32'd10);

    // counter wrap on the 4-bit instance
    do_reset();
    for (int i = 0; i <= 17; i++) begin
      logic lane;
      logic [15:0] d;
      lane = (i % 2 == 1);
      d = 16'h0100 + 16'(i);
      if (i == 17)
        step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      else if (lane)
        step(1'b0, 16'h0, 1'b1, d, 1'b1, 1'b0, 1'b1);
      else
        step(1'b1, d, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
      chk("wrap_narrow_cnt", {28'd0, n_beat_cnt}, 32'(i % 16));
      chk("wrap_wide_cnt", {24'd0, beat_cnt}, 32'(i));
    end

    // reset in the middle of a held beat
    step(1'b1, 16'h4444, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("t5_pre_o_valid", {31'd0, o_valid}, 32'd1);
    chk("t5_pre_o_data", {16'd0, o_data}, 32'h4444);
    do_reset();
    step(1'b1, 16'h7777, 1'b1, 16'h8888, 1'b1, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b1, 16'h8888, 1'b1, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    chk("t5_o_valid_drop", {31'd0, o_valid}, 32'd0);
    chk("t5_beat_cnt", {24'd0, beat_cnt}, 32'd2);

    repeat (3) @(posedge clk);
    #2;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
